// File: rtl/imem_responder_if.sv
// Fetch-side bus of the instruction-memory responder: request, response,
// flush and program-load signals.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both 1. The producer holds valid and its payload steady until that edge. The
// consumer may raise or drop ready freely; ready never depends on valid.
// req_* flows master->slave, rsp_* flows slave->master. ld_* and flush are
// single-cycle strobes sampled at the edge.
interface imem_responder_if;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] rsp_addr;
  logic        ld_we;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;

  modport master (
    output flush, req_valid, req_addr, rsp_ready, ld_we, ld_addr, ld_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err, rsp_addr
  );

  modport slave (
    input  flush, req_valid, req_addr, rsp_ready, ld_we, ld_addr, ld_data,
    output req_ready, rsp_valid, rsp_data, rsp_err, rsp_addr
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder. A fetch is checked and the word array read at
// the accept edge, the result rides a fixed LATENCY-stage shift pipeline and
// lands in a response FIFO. A credit counter (accepted minus consumed) throttles
// req_ready so the FIFO can never overflow. flush drops everything in flight.
module imem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1,
  parameter int RSP_DEPTH   = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  imem_responder_if.slave                 bus,
  output logic [$clog2(RSP_DEPTH+1)-1:0]  dbg_cnt,
  output logic [$clog2(RSP_DEPTH+1)-1:0]  dbg_q_cnt
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic        err;
    logic [31:0] addr;
    logic [31:0] data;
  } rsp_t;

  typedef struct packed {
    logic valid;
    rsp_t rsp;
  } pipe_t;

  // Program storage; deliberately not reset.
  logic [31:0] mem [DEPTH_WORDS];

  pipe_t          pipe_q [LATENCY];
  pipe_t          pipe_d [LATENCY];
  rsp_t           q_q    [RSP_DEPTH];
  rsp_t           q_d    [RSP_DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  q_cnt_q, q_cnt_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic        accept;
  logic        pop;
  logic        push;
  logic        req_err;
  logic [31:0] mem_rd;
  logic        ld_in_range;
  rsp_t        head;
  logic        unused_ld;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credits cover both in-flight pipeline entries and queued responses.
  assign bus.req_ready = !bus.flush && (cnt_q < CW'(RSP_DEPTH));
  assign accept        = bus.req_valid && bus.req_ready;
  assign pop           = bus.rsp_valid && bus.rsp_ready;
  assign push          = pipe_q[LATENCY-1].valid;

  assign req_err = (bus.req_addr[1:0] != 2'b00) ||
                   (bus.req_addr[31:2] >= 30'(DEPTH_WORDS));
  // Combinational read before the edge gives read-before-write on a same-edge load.
  assign mem_rd  = mem[bus.req_addr[AW+1:2]];

  assign ld_in_range = bus.ld_addr[31:2] < 30'(DEPTH_WORDS);
  assign unused_ld   = ^bus.ld_addr[1:0];

  assign head          = q_q[rd_ptr_q];
  assign bus.rsp_valid = (q_cnt_q != '0);
  assign bus.rsp_data  = bus.rsp_valid ? head.data : '0;
  assign bus.rsp_err   = bus.rsp_valid ? head.err  : 1'b0;
  assign bus.rsp_addr  = bus.rsp_valid ? head.addr : '0;

  assign dbg_cnt   = cnt_q;
  assign dbg_q_cnt = q_cnt_q;

  // Load port write; out-of-range words are dropped rather than aliased.
  always_ff @(posedge clk) begin
    if (bus.ld_we && ld_in_range) begin
      mem[bus.ld_addr[AW+1:2]] <= bus.ld_data;
    end
  end

  // Next state for the fixed-latency pipeline: stage 0 captures the accept.
  always_comb begin
    pipe_d[0].valid    = accept;
    pipe_d[0].rsp.err  = req_err;
    pipe_d[0].rsp.addr = bus.req_addr;
    pipe_d[0].rsp.data = req_err ? '0 : mem_rd;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    if (bus.flush) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_d[i].valid = 1'b0;
      end
    end
  end

  // Next state for the response FIFO and the credit counter.
  always_comb begin
    q_d      = q_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      q_d[wr_ptr_q] = pipe_q[LATENCY-1].rsp;
      wr_ptr_d      = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    q_cnt_d = q_cnt_q + CW'(push) - CW'(pop);
    cnt_d   = cnt_q + CW'(accept) - CW'(pop);
    // A handshake in the flush cycle is simply absorbed by the clear.
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      q_cnt_d  = '0;
      cnt_d    = '0;
    end
  end

  // State registers; reset drops anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
      for (int i = 0; i < RSP_DEPTH; i++) begin
        q_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      q_cnt_q  <= '0;
      cnt_q    <= '0;
    end else begin
      pipe_q   <= pipe_d;
      q_q      <= q_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      q_cnt_q  <= q_cnt_d;
      cnt_q    <= cnt_d;
    end
  end

  // Credits make a push into a full queue impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (q_cnt_q == CW'(RSP_DEPTH))));

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: reset, streaming, backpressure, errors,
// flush and load-port collision, each scenario in its own task.
module tb_imem_responder;
  logic clk;
  logic rst_n;
  logic [2:0] dbg_cnt;
  logic [2:0] dbg_q_cnt;
  int pass_cnt  = 0;
  int total_cnt = 0;

  imem_responder_if bus ();

  imem_responder #(
    .DEPTH_WORDS(1024),
    .LATENCY    (1),
    .RSP_DEPTH  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .dbg_cnt  (dbg_cnt),
    .dbg_q_cnt(dbg_q_cnt)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] addr, input logic [31:0] data);
    bus.ld_we   = 1'b1;
    bus.ld_addr = addr;
    bus.ld_data = data;
    tick();
    bus.ld_we   = 1'b0;
  endtask

  task automatic fetch_one(input logic [31:0] addr);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    while (!bus.req_ready && n < 20) begin
      tick();
      n++;
    end
    total_cnt++;
    if (bus.req_ready !== 1'b1) $display("FAIL accept_%h got req_ready=%b exp 1", addr, bus.req_ready);
    else pass_cnt++;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic [31:0] d, output logic e, output logic [31:0] a);
    int n = 0;
    bus.rsp_ready = 1'b1;
    while (!bus.rsp_valid && n < 20) begin
      tick();
      n++;
    end
    total_cnt++;
    if (bus.rsp_valid !== 1'b1) $display("FAIL rsp_arrival got rsp_valid=%b exp 1", bus.rsp_valid);
    else pass_cnt++;
    d = bus.rsp_data;
    e = bus.rsp_err;
    a = bus.rsp_addr;
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] d, a;
    logic e;
    rst_n = 1'b0;
    tick();
    tick();
    total_cnt++; if (bus.rsp_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", bus.rsp_valid); else pass_cnt++;
    total_cnt++; if (bus.rsp_data !== 32'h0) $display("FAIL rst_data got %h exp 0", bus.rsp_data); else pass_cnt++;
    total_cnt++; if (bus.rsp_err !== 1'b0) $display("FAIL rst_err got %b exp 0", bus.rsp_err); else pass_cnt++;
    total_cnt++; if (bus.rsp_addr !== 32'h0) $display("FAIL rst_addr got %h exp 0", bus.rsp_addr); else pass_cnt++;
    rst_n = 1'b1;
    tick();
    total_cnt++; if (bus.req_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", bus.req_ready); else pass_cnt++;
    total_cnt++; if (dbg_cnt !== 3'd0) $display("FAIL rst_cnt got %0d exp 0", dbg_cnt); else pass_cnt++;
    load_word(32'h0, 32'h0000_0013);
    load_word(32'h4, 32'h0010_0093);
    load_word(32'h8, 32'h0020_0113);
    load_word(32'hC, 32'h0030_0193);
    // Burst with responses held back, then reset in the middle of a cycle.
    bus.rsp_ready = 1'b0;
    fetch_one(32'h0);
    fetch_one(32'h8);
    total_cnt++; if (bus.rsp_valid !== 1'b1) $display("FAIL mid_valid got %b exp 1", bus.rsp_valid); else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (bus.rsp_valid !== 1'b0) $display("FAIL mid_rst_valid got %b exp 0", bus.rsp_valid); else pass_cnt++;
    total_cnt++; if (dbg_cnt !== 3'd0) $display("FAIL mid_rst_cnt got %0d exp 0", dbg_cnt); else pass_cnt++;
    #1;
    rst_n = 1'b1;
    tick();
    tick();
    total_cnt++; if (bus.rsp_valid !== 1'b0) $display("FAIL post_rst_valid got %b exp 0", bus.rsp_valid); else pass_cnt++;
    fetch_one(32'h4);
    get_rsp(d, e, a);
    total_cnt++; if (d !== 32'h0010_0093) $display("FAIL post_rst_data got %h exp 00100093", d); else pass_cnt++;
    total_cnt++; if (e !== 1'b0 || a !== 32'h4) $display("FAIL post_rst_meta got err=%b addr=%h exp err=0 addr=4", e, a); else pass_cnt++;
  endtask

  task automatic test_streaming();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0;
    tick();
    total_cnt++; if (bus.rsp_valid !== 1'b0) $display("FAIL str_lat got rsp_valid=%b exp 0", bus.rsp_valid); else pass_cnt++;
    bus.req_addr = 32'h4;
    tick();
    total_cnt++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h0000_0013 || bus.rsp_addr !== 32'h0)
      $display("FAIL str_r0 got v=%b d=%h a=%h exp v=1 d=00000013 a=0", bus.rsp_valid, bus.rsp_data, bus.rsp_addr);
    else pass_cnt++;
    bus.req_addr = 32'h8;
    tick();
    bus.req_valid = 1'b0;
    total_cnt++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h0010_0093 || bus.rsp_addr !== 32'h4)
      $display("FAIL str_r1 got v=%b d=%h a=%h exp v=1 d=00100093 a=4", bus.rsp_valid, bus.rsp_data, bus.rsp_addr);
    else pass_cnt++;
    total_cnt++; if (dbg_cnt !== 3'd2) $display("FAIL str_cnt got %0d exp 2", dbg_cnt); else pass_cnt++;
    tick();
    total_cnt++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h0020_0113 || bus.rsp_addr !== 32'h8)
      $display("FAIL str_r2 got v=%b d=%h a=%h exp v=1 d=00200113 a=8", bus.rsp_valid, bus.rsp_data, bus.rsp_addr);
    else pass_cnt++;
    tick();
    total_cnt++; if (bus.rsp_valid !== 1'b0 || dbg_cnt !== 3'd0)
      $display("FAIL str_end got v=%b cnt=%0d exp v=0 cnt=0", bus.rsp_valid, dbg_cnt);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_d [4];
    logic [31:0] d, a;
    logic e;
    int acc = 0;
    exp_d[0] = 32'h0000_0013;
    exp_d[1] = 32'h0010_0093;
    exp_d[2] = 32'h0020_0113;
    exp_d[3] = 32'h0030_0193;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      bus.req_addr = 32'(acc * 4);
      if (bus.req_ready) acc++;
      tick();
    end
    bus.req_valid = 1'b0;
    total_cnt++; if (acc !== 4) $display("FAIL bp_accepts got %0d exp 4", acc); else pass_cnt++;
    total_cnt++; if (bus.req_ready !== 1'b0 || dbg_cnt !== 3'd4)
      $display("FAIL bp_full got ready=%b cnt=%0d exp ready=0 cnt=4", bus.req_ready, dbg_cnt);
    else pass_cnt++;
    total_cnt++; if (bus.rsp_data !== 32'h0000_0013) $display("FAIL bp_hold got %h exp 00000013", bus.rsp_data); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      get_rsp(d, e, a);
      total_cnt++; if (d !== exp_d[i] || a !== 32'(i * 4) || e !== 1'b0)
        $display("FAIL bp_drain%0d got d=%h a=%h e=%b exp d=%h a=%h e=0", i, d, a, e, exp_d[i], 32'(i * 4));
      else pass_cnt++;
    end
    total_cnt++; if (bus.rsp_valid !== 1'b0 || dbg_cnt !== 3'd0)
      $display("FAIL bp_empty got v=%b cnt=%0d exp v=0 cnt=0", bus.rsp_valid, dbg_cnt);
    else pass_cnt++;
  endtask

  task automatic test_errors();
    logic [31:0] d, a;
    logic e;
    load_word(32'hFFC, 32'hCAFE_F00D);
    fetch_one(32'h2);
    get_rsp(d, e, a);
    total_cnt++; if (e !== 1'b1 || d !== 32'h0 || a !== 32'h2)
      $display("FAIL err_misal got e=%b d=%h a=%h exp e=1 d=0 a=2", e, d, a);
    else pass_cnt++;
    fetch_one(32'h1000);
    get_rsp(d, e, a);
    total_cnt++; if (e !== 1'b1 || d !== 32'h0 || a !== 32'h1000)
      $display("FAIL err_range got e=%b d=%h a=%h exp e=1 d=0 a=1000", e, d, a);
    else pass_cnt++;
    fetch_one(32'hFFC);
    get_rsp(d, e, a);
    total_cnt++; if (e !== 1'b0 || d !== 32'hCAFE_F00D)
      $display("FAIL err_last got e=%b d=%h exp e=0 d=cafef00d", e, d);
    else pass_cnt++;
    fetch_one(32'h0);
    get_rsp(d, e, a);
    total_cnt++; if (e !== 1'b0 || d !== 32'h0000_0013)
      $display("FAIL err_after got e=%b d=%h exp e=0 d=00000013", e, d);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    logic [31:0] d, a;
    logic e;
    bus.rsp_ready = 1'b0;
    fetch_one(32'h0);
    fetch_one(32'h4);
    fetch_one(32'h8);
    bus.flush     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'hC;
    #1;
    total_cnt++; if (bus.req_ready !== 1'b0) $display("FAIL fl_ready got %b exp 0", bus.req_ready); else pass_cnt++;
    tick();
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    total_cnt++; if (bus.rsp_valid !== 1'b0 || dbg_cnt !== 3'd0)
      $display("FAIL fl_clear got v=%b cnt=%0d exp v=0 cnt=0", bus.rsp_valid, dbg_cnt);
    else pass_cnt++;
    tick();
    tick();
    total_cnt++; if (bus.rsp_valid !== 1'b0) $display("FAIL fl_noaccept got v=%b exp 0", bus.rsp_valid); else pass_cnt++;
    fetch_one(32'h8);
    get_rsp(d, e, a);
    total_cnt++; if (d !== 32'h0020_0113 || a !== 32'h8)
      $display("FAIL fl_next got d=%h a=%h exp d=00200113 a=8", d, a);
    else pass_cnt++;
    total_cnt++; if (bus.rsp_valid !== 1'b0) $display("FAIL fl_only got v=%b exp 0", bus.rsp_valid); else pass_cnt++;
  endtask

  task automatic test_load_collision();
    logic [31:0] d, a;
    logic e;
    bus.ld_we     = 1'b1;
    bus.ld_addr   = 32'h4;
    bus.ld_data   = 32'hDEAD_BEEF;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h4;
    tick();
    bus.ld_we     = 1'b0;
    bus.req_valid = 1'b0;
    get_rsp(d, e, a);
    total_cnt++; if (d !== 32'h0010_0093) $display("FAIL ld_old got %h exp 00100093", d); else pass_cnt++;
    fetch_one(32'h4);
    get_rsp(d, e, a);
    total_cnt++; if (d !== 32'hDEAD_BEEF) $display("FAIL ld_new got %h exp deadbeef", d); else pass_cnt++;
    // Out-of-range write must not alias onto word 0.
    load_word(32'h1000, 32'h0000_0055);
    fetch_one(32'h0);
    get_rsp(d, e, a);
    total_cnt++; if (d !== 32'h0000_0013) $display("FAIL ld_drop got %h exp 00000013", d); else pass_cnt++;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.rsp_ready = 1'b0;
    bus.ld_we     = 1'b0;
    bus.ld_addr   = '0;
    bus.ld_data   = '0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_errors();
    test_flush();
    test_load_collision();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
